// File: rtl/clause_table_pkg.sv
// Shared state encoding and sizing helpers for the banked clause table.
package clause_table_pkg;

   typedef logic [1:0] ct_state_e;
   localparam ct_state_e CT_IDLE = 2'd0;
   localparam ct_state_e CT_LOAD = 2'd1;
   localparam ct_state_e CT_RUN  = 2'd2;

   function automatic int ct_width(input int vaw, input int nsat, input int cc);
      return (vaw + 1) * (nsat - 1) * cc;
   endfunction

   // Never returns 0, so derived select/pointer vectors always have at least one bit.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/clause_bank_ram.sv
// One clause-row bank: simple dual-port RAM, one write and one registered read per cycle.
// Read data appears the cycle after rd_en_i and holds until the next read; contents survive reset.
module clause_bank_ram #(
   parameter int WIDTH = 480,
   parameter int ROWS  = 512,
   parameter int AW    = 9
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_row_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_row_i,
   output logic [WIDTH-1:0] rd_dat_o
);

   logic [WIDTH-1:0] mem_q [ROWS];
   logic [WIDTH-1:0] rd_dat_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_row_i] <= wr_dat_i;
      if (rd_en_i) rd_dat_q <= mem_q[rd_row_i];
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/clause_table_mp.sv
// Banked multi-channel clause table: LOAD mode accepts row writes, RUN mode serves NUM_RD read channels.
// Reads return after 1 cycle; bank collisions are round-robin arbitrated and losers see rd_ready_o=0.
module clause_table_mp
   import clause_table_pkg::*;
#(
   parameter int CLAUSE_COUNT           = 20,
   parameter int DEPTH                  = 2048,
   parameter int VARIABLE_ADDRESS_WIDTH = 11,
   parameter int NSAT                   = 3,
   parameter int NUM_RD                 = 4,
   parameter int NUM_BANKS              = 4,
   localparam int CT_WIDTH = ct_width(VARIABLE_ADDRESS_WIDTH, NSAT, CLAUSE_COUNT)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 load_start_i,
   input  logic                                 load_done_i,
   input  logic                                 wr_en_i,
   input  logic [VARIABLE_ADDRESS_WIDTH-1:0]    wr_addr_i,
   input  logic [CT_WIDTH-1:0]                  wr_clauses_i,
   output logic                                 wr_err_o,
   output logic                                 running_o,
   input  logic [NUM_RD-1:0]                    rd_valid_i,
   input  logic [NUM_RD*VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_i,
   output logic [NUM_RD-1:0]                    rd_ready_o,
   output logic [NUM_RD*CT_WIDTH-1:0]           clauses_o,
   output logic [NUM_RD-1:0]                    clauses_valid_o
);

   localparam int W    = VARIABLE_ADDRESS_WIDTH;
   localparam int ROWS = DEPTH / NUM_BANKS;
   localparam int RAW  = clog2(ROWS);
   localparam int BSW  = clog2(NUM_BANKS);
   localparam int PW   = clog2(NUM_RD);

   ct_state_e           state_q, state_d;
   logic                running_q, running_d;
   logic                wr_err_q, wr_err_d;
   logic [NUM_RD-1:0]   vld_q, vld_d;
   logic [NUM_RD-1:0]   oor_q, oor_d;
   logic [BSW-1:0]      bank_q [NUM_RD];
   logic [BSW-1:0]      bank_d [NUM_RD];
   logic [CT_WIDTH-1:0] hold_q [NUM_RD];
   logic [CT_WIDTH-1:0] hold_d [NUM_RD];

   logic                run_ok, wr_acc;
   logic [BSW-1:0]      wr_bank;
   logic [RAW-1:0]      wr_row;
   logic [NUM_RD-1:0]   req_in, req_oor, rd_rdy;
   logic [BSW-1:0]      req_bank [NUM_RD];
   logic [RAW-1:0]      req_row  [NUM_RD];
   logic [CT_WIDTH-1:0] slot_dat [NUM_RD];
   logic [NUM_BANKS-1:0][NUM_RD-1:0] bank_gnt;
   logic [CT_WIDTH-1:0] bank_dat [NUM_BANKS];

   always_comb begin
      state_d = state_q;
      case (state_q)
         CT_IDLE: if (load_start_i) state_d = CT_LOAD;
         CT_LOAD: if (load_done_i && !load_start_i) state_d = CT_RUN;
         CT_RUN:  if (load_start_i) state_d = CT_LOAD;
         default: state_d = CT_IDLE;
      endcase
      running_d = (state_d == CT_RUN);

      wr_acc   = (state_q == CT_LOAD) && !rst_i && wr_en_i && (int'(wr_addr_i) < DEPTH);
      wr_err_d = wr_en_i && !wr_acc;
      wr_bank  = BSW'(int'(wr_addr_i) % NUM_BANKS);
      wr_row   = RAW'(int'(wr_addr_i) / NUM_BANKS);

      // Out-of-range reads bypass arbitration: they are consumed and answered with zeros.
      run_ok = (state_q == CT_RUN) && !rst_i;
      for (int k = 0; k < NUM_RD; k++) begin
         req_in[k]   = run_ok && rd_valid_i[k] && (int'(rd_addr_i[k*W +: W]) <  DEPTH);
         req_oor[k]  = run_ok && rd_valid_i[k] && (int'(rd_addr_i[k*W +: W]) >= DEPTH);
         req_bank[k] = BSW'(int'(rd_addr_i[k*W +: W]) % NUM_BANKS);
         req_row[k]  = RAW'(int'(rd_addr_i[k*W +: W]) / NUM_BANKS);
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [PW-1:0]     ptr_q, ptr_d, idx;
      logic [NUM_RD-1:0] gnt;
      logic [RAW-1:0]    rd_row;
      logic              found;

      always_comb begin
         gnt    = '0;
         rd_row = '0;
         ptr_d  = ptr_q;
         idx    = '0;
         found  = 1'b0;
         for (int i = 0; i < NUM_RD; i++) begin
            idx = PW'((int'(ptr_q) + i) % NUM_RD);
            if (!found && req_in[idx] && (req_bank[idx] == BSW'(b))) begin
               found    = 1'b1;
               gnt[idx] = 1'b1;
               rd_row   = req_row[idx];
               ptr_d    = PW'((int'(idx) + 1) % NUM_RD);
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) ptr_q <= '0;
         else       ptr_q <= ptr_d;
      end

      assign bank_gnt[b] = gnt;

      clause_bank_ram #(.WIDTH(CT_WIDTH), .ROWS(ROWS), .AW(RAW)) u_ram (
         .clk_i    (clk_i),
         .wr_en_i  (wr_acc && (wr_bank == BSW'(b))),
         .wr_row_i (wr_row),
         .wr_dat_i (wr_clauses_i),
         .rd_en_i  (|gnt),
         .rd_row_i (rd_row),
         .rd_dat_o (bank_dat[b])
      );
   end

   // A slot shows fresh bank data only in its valid cycle, then replays the captured copy.
   always_comb begin
      clauses_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_rdy[k] = req_oor[k];
         for (int b = 0; b < NUM_BANKS; b++) rd_rdy[k] = rd_rdy[k] | bank_gnt[b][k];
         vld_d[k]    = rd_rdy[k];
         oor_d[k]    = req_oor[k];
         bank_d[k]   = req_bank[k];
         slot_dat[k] = !vld_q[k] ? hold_q[k] : (oor_q[k] ? '0 : bank_dat[bank_q[k]]);
         hold_d[k]   = slot_dat[k];
         clauses_o[k*CT_WIDTH +: CT_WIDTH] = slot_dat[k];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= CT_IDLE;
         running_q <= 1'b0;
         wr_err_q  <= 1'b0;
         vld_q     <= '0;
         oor_q     <= '0;
         for (int k = 0; k < NUM_RD; k++) begin
            bank_q[k] <= '0;
            hold_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         wr_err_q  <= wr_err_d;
         vld_q     <= vld_d;
         oor_q     <= oor_d;
         for (int k = 0; k < NUM_RD; k++) begin
            bank_q[k] <= bank_d[k];
            hold_q[k] <= hold_d[k];
         end
      end
   end

   assign rd_ready_o      = rd_rdy;
   assign clauses_valid_o = vld_q;
   assign running_o       = running_q;
   assign wr_err_o        = wr_err_q;

endmodule

// File: tb/tb_clause_table_mp.sv
// Directed bench for clause_table_mp (DEPTH=2000): load/readback, banking, arbitration, mode guards, reset.
module tb_clause_table_mp;

   localparam int W  = 11;
   localparam int NR = 4;
   localparam int CT = (11 + 1) * (3 - 1) * 20;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              load_start_i, load_done_i, wr_en_i;
   logic [W-1:0]      wr_addr_i;
   logic [CT-1:0]     wr_clauses_i;
   logic              wr_err_o, running_o;
   logic [NR-1:0]     rd_valid_i, rd_ready_o, clauses_valid_o;
   logic [NR*W-1:0]   rd_addr_i;
   logic [NR*CT-1:0]  clauses_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   clause_table_mp #(.DEPTH(2000)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .load_start_i    (load_start_i),
      .load_done_i     (load_done_i),
      .wr_en_i         (wr_en_i),
      .wr_addr_i       (wr_addr_i),
      .wr_clauses_i    (wr_clauses_i),
      .wr_err_o        (wr_err_o),
      .running_o       (running_o),
      .rd_valid_i      (rd_valid_i),
      .rd_addr_i       (rd_addr_i),
      .rd_ready_o      (rd_ready_o),
      .clauses_o       (clauses_o),
      .clauses_valid_o (clauses_valid_o)
   );

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_addr(input int k, input int a);
      rd_addr_i[k*W +: W] = W'(a);
   endtask

   function automatic logic [511:0] slot(input int k);
      return 512'(clauses_o[k*CT +: CT]);
   endfunction

   function automatic logic [511:0] row_dat(input int r);
      return 512'(r * 32'h1111);
   endfunction

   initial begin
      rst_i = 1'b1; load_start_i = 1'b0; load_done_i = 1'b0; wr_en_i = 1'b0;
      wr_addr_i = '0; wr_clauses_i = '0; rd_valid_i = '0; rd_addr_i = '0;
      tick(); tick();
      rst_i = 1'b0;
      rd_valid_i = 4'hf;
      #1;
      chk("rst_running", 512'(running_o), 0);
      chk("rst_wr_err", 512'(wr_err_o), 0);
      chk("rst_valid", 512'(clauses_valid_o), 0);
      chk("rst_data", 512'(clauses_o[511:0]), 0);
      chk("idle_ready", 512'(rd_ready_o), 0);
      rd_valid_i = '0;

      // Write in IDLE is dropped with an error pulse
      wr_en_i = 1'b1; wr_addr_i = 11'd3; wr_clauses_i = '1;
      tick();
      wr_en_i = 1'b0;
      chk("idle_wr_err", 512'(wr_err_o), 1);

      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
      chk("load_running", 512'(running_o), 0);
      rd_valid_i = 4'b0001; set_addr(0, 5);
      #1;
      chk("load_rd_ready", 512'(rd_ready_o), 0);
      rd_valid_i = '0;

      // Row address equal to DEPTH is out of range
      wr_en_i = 1'b1; wr_addr_i = 11'd2000;
      tick();
      wr_en_i = 1'b0;
      chk("oor_wr_err", 512'(wr_err_o), 1);
      tick();
      chk("wr_err_pulse", 512'(wr_err_o), 0);

      // Rows 0..15; the last write shares its cycle with load_done_i
      for (int r = 0; r < 16; r++) begin
         wr_en_i = 1'b1; wr_addr_i = W'(r); wr_clauses_i = CT'(r * 32'h1111);
         load_done_i = (r == 15);
         tick();
         if (r == 0) chk("load_wr_ok", 512'(wr_err_o), 0);
      end
      wr_en_i = 1'b0; load_done_i = 1'b0;
      chk("run_running", 512'(running_o), 1);

      rd_valid_i = 4'b0001; set_addr(0, 5);
      #1;
      chk("rd5_ready", 512'(rd_ready_o), 4'b0001);
      tick();
      rd_valid_i = '0;
      chk("rd5_valid", 512'(clauses_valid_o), 4'b0001);
      chk("rd5_data", slot(0), row_dat(5));
      tick();
      chk("rd5_valid_clr", 512'(clauses_valid_o), 0);
      chk("rd5_hold", slot(0), row_dat(5));

      // All channels on row 4 (bank 0): grants rotate 0,1,2,3
      rd_valid_i = 4'hf;
      for (int k = 0; k < NR; k++) set_addr(k, 4);
      for (int c = 0; c < NR; c++) begin
         #1;
         chk($sformatf("rr_ready%0d", c), 512'(rd_ready_o), 512'(1 << c));
         tick();
         chk($sformatf("rr_valid%0d", c), 512'(clauses_valid_o), 512'(1 << c));
         chk($sformatf("rr_data%0d", c), slot(c), row_dat(4));
      end
      rd_valid_i = '0;
      tick();

      rd_valid_i = 4'hf;
      for (int k = 0; k < NR; k++) set_addr(k, k);
      #1;
      chk("par_ready", 512'(rd_ready_o), 4'hf);
      tick();
      rd_valid_i = '0;
      chk("par_valid", 512'(clauses_valid_o), 4'hf);
      for (int k = 0; k < NR; k++) chk($sformatf("par_data%0d", k), slot(k), row_dat(k));

      // Write in RUN is dropped
      wr_en_i = 1'b1; wr_addr_i = 11'd5; wr_clauses_i = CT'(32'hdead);
      tick();
      wr_en_i = 1'b0;
      chk("run_wr_err", 512'(wr_err_o), 1);
      rd_valid_i = 4'b0001; set_addr(0, 5);
      tick();
      rd_valid_i = '0;
      chk("run_wr_valid", 512'(clauses_valid_o), 4'b0001);
      chk("run_wr_unchanged", slot(0), row_dat(5));

      rd_valid_i = 4'b0100; set_addr(2, 2040);
      #1;
      chk("oor_rd_ready", 512'(rd_ready_o), 4'b0100);
      tick();
      rd_valid_i = '0;
      chk("oor_rd_valid", 512'(clauses_valid_o), 4'b0100);
      chk("oor_rd_data", slot(2), 0);

      rd_valid_i = 4'b1010; set_addr(1, 2000); set_addr(3, 7);
      #1;
      chk("mix_ready", 512'(rd_ready_o), 4'b1010);
      tick();
      rd_valid_i = '0;
      chk("mix_valid", 512'(clauses_valid_o), 4'b1010);
      chk("mix_oor_data", slot(1), 0);
      chk("mix_row7_data", slot(3), row_dat(7));

      // Reset the cycle after an accepted read
      rd_valid_i = 4'b0001; set_addr(0, 6);
      #1;
      chk("pre_rst_ready", 512'(rd_ready_o), 4'b0001);
      tick();
      rd_valid_i = '0; rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("mid_rst_valid", 512'(clauses_valid_o), 0);
      chk("mid_rst_running", 512'(running_o), 0);
      chk("mid_rst_data", slot(0), 0);
      load_done_i = 1'b1;
      tick();
      load_done_i = 1'b0;
      chk("idle_ignores_done", 512'(running_o), 0);

      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0; load_done_i = 1'b1;
      tick();
      load_done_i = 1'b0;
      chk("reload_running", 512'(running_o), 1);
      rd_valid_i = 4'b1001; set_addr(0, 6); set_addr(3, 3);
      #1;
      chk("reload_ready", 512'(rd_ready_o), 4'b1001);
      tick();
      rd_valid_i = '0;
      chk("reload_valid", 512'(clauses_valid_o), 4'b1001);
      chk("reload_row6", slot(0), row_dat(6));
      chk("reload_row3", slot(3), row_dat(3));

      // Read accepted in the last RUN cycle still completes
      rd_valid_i = 4'b0001; set_addr(0, 9); load_start_i = 1'b1;
      #1;
      chk("last_run_ready", 512'(rd_ready_o), 4'b0001);
      tick();
      load_start_i = 1'b0;
      chk("last_run_valid", 512'(clauses_valid_o), 4'b0001);
      chk("last_run_data", slot(0), row_dat(9));
      chk("last_run_running", 512'(running_o), 0);
      chk("load2_rd_ready", 512'(rd_ready_o), 0);
      rd_valid_i = '0;

      load_start_i = 1'b1; load_done_i = 1'b1;
      tick();
      load_start_i = 1'b0; load_done_i = 1'b0;
      chk("start_beats_done", 512'(running_o), 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
